// File: rtl/config_cell_dbuf_pkg.sv
// Shared types and sizing helpers for the double-buffered configuration cell.
// Provides: cfg_state_t fill-state enum, cfg_depth() ceil-divide, cfg_cnt_w().
package config_cell_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        PRIMED  = 2'd2
    } cfg_state_t;

    // Shifts needed to fill a cell of 'size' bits, 'chain_w' lanes at a time.
    function automatic int cfg_depth(input int size, input int chain_w);
        return (size + chain_w - 1) / chain_w;
    endfunction

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cfg_cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/config_cell_dbuf_if.sv
// Configuration chain bundle: shift data, enable, commit/capture strobes,
// and the cell's active select plus status flags.
// master = configuration loader side, slave = configuration cell side.
interface config_cell_dbuf_if #(
    parameter int SIZE    = 1,
    parameter int CHAIN_W = 1
);
    logic               Config_En;
    logic [CHAIN_W-1:0] ConfigIn;
    logic [CHAIN_W-1:0] ConfigOut;
    logic               Config_Commit;
    logic               Config_Capture;
    logic [SIZE-1:0]    select;
    logic               cfg_primed;
    logic               cfg_valid;
    logic               cfg_error;

    modport master (
        output Config_En, ConfigIn, Config_Commit, Config_Capture,
        input  ConfigOut, select, cfg_primed, cfg_valid, cfg_error
    );

    modport slave (
        input  Config_En, ConfigIn, Config_Commit, Config_Capture,
        output ConfigOut, select, cfg_primed, cfg_valid, cfg_error
    );
endinterface

// File: rtl/config_cell_dbuf_shift_stage.sv
// Shadow shift register: DEPTH words of CHAIN_W lanes, new word enters at
// the top, oldest word leaves at the bottom. Parallel load has priority.
// Ports: clk, rst_n (sync, active-low), en, load, load_data, din, shadow.
module config_shift_stage #(
    parameter int CHAIN_W = 1,
    parameter int DEPTH   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       load,
    input  logic [DEPTH*CHAIN_W-1:0]   load_data,
    input  logic [CHAIN_W-1:0]         din,
    output logic [DEPTH*CHAIN_W-1:0]   shadow
);
    localparam int W = DEPTH * CHAIN_W;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= load_data;
        end else if (en) begin
            // {din, shadow[W-1:CHAIN_W]}, written so DEPTH=1 needs no slice
            shadow <= W'({din, shadow} >> CHAIN_W);
        end
    end
endmodule

// File: rtl/config_cell_dbuf.sv
// CGRA configuration cell: shadow shift chain plus atomically committed
// active register, with fill tracking and a sticky premature-commit flag.
// Ports: Config_Clock, Config_Reset_n (sync, active-low), bus (slave).
// Optional: CONFIG_READBACK_EN enables Config_Capture (active -> shadow).
module config_cell_dbuf
    import config_cell_pkg::*;
#(
    parameter int SIZE    = 1,
    parameter int CHAIN_W = 1
) (
    input  logic                 Config_Clock,
    input  logic                 Config_Reset_n,
    config_cell_dbuf_if.slave    bus
);
    localparam int DEPTH = cfg_depth(SIZE, CHAIN_W);
    localparam int W     = DEPTH * CHAIN_W;
    localparam int CNT_W = cfg_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    // State after the first shift of a fill: a one-word cell is already full.
    localparam cfg_state_t FIRST_ST = (DEPTH == 1) ? PRIMED : FILLING;

    logic [W-1:0]     shadow;
    logic [W-1:0]     load_data;
    logic [SIZE-1:0]  active;
    logic [CNT_W-1:0] count;
    cfg_state_t       state;
    logic             valid;
    logic             error;
    logic             capture;
    logic             unused_shadow;

`ifdef CONFIG_READBACK_EN
    // Commit wins over a same-cycle capture.
    assign capture = bus.Config_Capture & ~bus.Config_Commit;
    always_comb begin
        load_data              = '0;
        load_data[SIZE-1:0]    = active;
    end
`else
    logic unused_capture;
    assign unused_capture = bus.Config_Capture;
    assign capture        = 1'b0;
    assign load_data      = '0;
`endif

    config_shift_stage #(
        .CHAIN_W (CHAIN_W),
        .DEPTH   (DEPTH)
    ) u_shift (
        .clk       (Config_Clock),
        .rst_n     (Config_Reset_n),
        .en        (bus.Config_En & ~capture),
        .load      (capture),
        .load_data (load_data),
        .din       (bus.ConfigIn),
        .shadow    (shadow)
    );

    always_ff @(posedge Config_Clock) begin
        if (!Config_Reset_n) begin
            active <= '0;
            count  <= '0;
            state  <= EMPTY;
            valid  <= 1'b0;
            error  <= 1'b0;
        end else if (bus.Config_Commit) begin
            // Decision uses pre-shift state and shadow.
            if (state == PRIMED) begin
                active <= shadow[SIZE-1:0];
                valid  <= 1'b1;
                error  <= 1'b0;
            end else begin
                error  <= 1'b1;
            end
            if (bus.Config_En) begin
                count <= CNT_W'(1);
                state <= FIRST_ST;
            end else begin
                count <= '0;
                state <= EMPTY;
            end
        end else if (capture) begin
            count <= '0;
            state <= EMPTY;
        end else if (bus.Config_En) begin
            if (count != DEPTH_C)
                count <= count + CNT_W'(1);
            state <= (count >= DEPTH_C - CNT_W'(1)) ? PRIMED : FILLING;
        end
    end

    assign unused_shadow  = ^shadow;
    assign bus.ConfigOut  = shadow[CHAIN_W-1:0];
    assign bus.select     = active;
    assign bus.cfg_primed = (state == PRIMED);
    assign bus.cfg_valid  = valid;
    assign bus.cfg_error  = error;
endmodule

// File: tb/tb_config_cell_dbuf.sv
// Directed self-checking bench for config_cell_dbuf (SIZE=10, CHAIN_W=4).
// Readback steps are built when CONFIG_READBACK_EN is defined.
module tb_config_cell_dbuf;
    localparam int SIZE    = 10;
    localparam int CHAIN_W = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    config_cell_dbuf_if #(.SIZE(SIZE), .CHAIN_W(CHAIN_W)) bus ();

    config_cell_dbuf #(.SIZE(SIZE), .CHAIN_W(CHAIN_W)) dut (
        .Config_Clock   (clk),
        .Config_Reset_n (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic en, input logic [3:0] din,
                        input logic cm, input logic cp);
        rst_n              = r;
        bus.Config_En      = en;
        bus.ConfigIn       = din;
        bus.Config_Commit  = cm;
        bus.Config_Capture = cp;
        @(posedge clk);
        #1;
        rst_n              = 1'b1;
        bus.Config_En      = 1'b0;
        bus.Config_Commit  = 1'b0;
        bus.Config_Capture = 1'b0;
    endtask

    task automatic shift(input logic [3:0] d);
        step(1'b1, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic commit();
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.Config_En = 1'b1;
        bus.ConfigIn = 4'hF;
        bus.Config_Commit = 1'b0;
        bus.Config_Capture = 1'b0;

        // Reset held 2 edges with shift requested
        step(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        chk("rst_select", 32'(bus.select), 32'h000);
        chk("rst_out", 32'(bus.ConfigOut), 32'h0);
        chk("rst_primed", 32'(bus.cfg_primed), 32'h0);
        chk("rst_valid", 32'(bus.cfg_valid), 32'h0);
        chk("rst_error", 32'(bus.cfg_error), 32'h0);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("idle_out", 32'(bus.ConfigOut), 32'h0);

        // Load 0x321 and commit
        shift(4'h1); chk("ld_out1", 32'(bus.ConfigOut), 32'h0);
        shift(4'h2); chk("ld_out2", 32'(bus.ConfigOut), 32'h0);
        chk("ld_primed2", 32'(bus.cfg_primed), 32'h0);
        shift(4'h3); chk("ld_out3", 32'(bus.ConfigOut), 32'h1);
        chk("ld_primed3", 32'(bus.cfg_primed), 32'h1);
        chk("ld_sel_pre", 32'(bus.select), 32'h000);
        commit();
        chk("cm_select", 32'(bus.select), 32'h321);
        chk("cm_valid", 32'(bus.cfg_valid), 32'h1);
        chk("cm_primed", 32'(bus.cfg_primed), 32'h0);
        chk("cm_error", 32'(bus.cfg_error), 32'h0);

        // Premature commit after 2 words
        shift(4'h4);
        shift(4'h5);
        commit();
        chk("pre_error", 32'(bus.cfg_error), 32'h1);
        chk("pre_select", 32'(bus.select), 32'h321);
        chk("pre_valid", 32'(bus.cfg_valid), 32'h1);
        // Full load clears error; pad bits of 0x987 are dropped
        shift(4'h7);
        shift(4'h8);
        shift(4'h9);
        chk("err_sticky", 32'(bus.cfg_error), 32'h1);
        commit();
        chk("good_error", 32'(bus.cfg_error), 32'h0);
        chk("good_select", 32'(bus.select), 32'h187);

        // Clean shadow, then pass-through of 5 words
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("rst2_select", 32'(bus.select), 32'h000);
        chk("rst2_valid", 32'(bus.cfg_valid), 32'h0);
        shift(4'h1); chk("pt_out1", 32'(bus.ConfigOut), 32'h0);
        shift(4'h2); chk("pt_out2", 32'(bus.ConfigOut), 32'h0);
        shift(4'h3); chk("pt_out3", 32'(bus.ConfigOut), 32'h1);
        shift(4'h4); chk("pt_out4", 32'(bus.ConfigOut), 32'h2);
        chk("pt_primed4", 32'(bus.cfg_primed), 32'h1);
        shift(4'h5); chk("pt_out5", 32'(bus.ConfigOut), 32'h3);
        chk("pt_primed5", 32'(bus.cfg_primed), 32'h1);

        // Commit with shift: pre-shift shadow {5,4,3} -> 0x543 & 0x3FF
        step(1'b1, 1'b1, 4'h6, 1'b1, 1'b0);
        chk("cs_select", 32'(bus.select), 32'h143);
        chk("cs_out", 32'(bus.ConfigOut), 32'h4);
        chk("cs_primed", 32'(bus.cfg_primed), 32'h0);
        chk("cs_error", 32'(bus.cfg_error), 32'h0);
        // count=1 after that cycle, so 2 more shifts prime the cell
        shift(4'hA); chk("cs_primed_a", 32'(bus.cfg_primed), 32'h0);
        shift(4'hB); chk("cs_primed_b", 32'(bus.cfg_primed), 32'h1);
        commit();
        chk("cs_select2", 32'(bus.select), 32'h3A6);
        chk("cs_error2", 32'(bus.cfg_error), 32'h0);

        // Reset mid-load
        shift(4'h1);
        shift(4'h2);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("mid_out", 32'(bus.ConfigOut), 32'h0);
        chk("mid_select", 32'(bus.select), 32'h000);
        chk("mid_primed", 32'(bus.cfg_primed), 32'h0);
        shift(4'h5); chk("mid_out1", 32'(bus.ConfigOut), 32'h0);
        shift(4'hA); chk("mid_out2", 32'(bus.ConfigOut), 32'h0);
        chk("mid_primed2", 32'(bus.cfg_primed), 32'h0);
        shift(4'h2); chk("mid_out3", 32'(bus.ConfigOut), 32'h5);
        commit();
        chk("mid_select2", 32'(bus.select), 32'h2A5);
        chk("mid_error", 32'(bus.cfg_error), 32'h0);
        chk("mid_valid", 32'(bus.cfg_valid), 32'h1);

`ifdef CONFIG_READBACK_EN
        // Readback of 0x2A5, LSB word first
        shift(4'h7);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("rb_out0", 32'(bus.ConfigOut), 32'h5);
        chk("rb_primed", 32'(bus.cfg_primed), 32'h0);
        shift(4'h0); chk("rb_out1", 32'(bus.ConfigOut), 32'hA);
        shift(4'h0); chk("rb_out2", 32'(bus.ConfigOut), 32'h2);
        shift(4'h0); chk("rb_out3", 32'(bus.ConfigOut), 32'h0);
        chk("rb_primed3", 32'(bus.cfg_primed), 32'h1);
        // Capture with commit: commit of zero shadow wins
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("rbc_select", 32'(bus.select), 32'h000);
        chk("rbc_out", 32'(bus.ConfigOut), 32'h0);
        chk("rbc_error", 32'(bus.cfg_error), 32'h0);
`else
        // Capture ignored: shadow {7,2,A} keeps streaming
        shift(4'h7);
        step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("nocap_out", 32'(bus.ConfigOut), 32'hA);
        chk("nocap_primed", 32'(bus.cfg_primed), 32'h0);
        chk("nocap_select", 32'(bus.select), 32'h2A5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
